vga_pattern_gen: RTL and testbench

Parametrised, multi-mode successor to the frame data generator that feeds the SDRAM frame buffer write port. On each frame-sync pulse it streams one frame region of `H_ACTIVE × V_LINES` RGB565 words to the memory arbiter's write side. Each word is issued under the arbiter's ready signal. The generator selects among solid, colour-bar, gradient, checkerboard and address-counter patterns, and reports frame completion and missed frame syncs. It sits in the write clock domain between the VGA frame sync and the memory arbiter write FIFO.

---
 rtl/vga_pattern_gen_if.sv | 9 +
 rtl/vga_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Write-side link between the pattern generator and the memory arbiter write FIFO.
interface vga_pattern_gen_if;
   logic        wr_en;
   logic        data_en;
   logic [15:0] dout;

   modport master (input wr_en, output data_en, output dout);
   modport slave  (output wr_en, input data_en, input dout);
endinterface

// File: rtl/vga_pattern_gen.sv
// Streams one H_ACTIVE x V_LINES frame of RGB565 words per frame sync, paced by
// the arbiter ready, with selectable test patterns and frame/overrun status.
module vga_pattern_gen #(
   parameter int H_ACTIVE   = 1024,
   parameter int V_LINES    = 40,
   parameter int CHECK_LOG2 = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [2:0]        mode_i,
   input  logic [15:0]       fg_color_i,
   vga_pattern_gen_if.master wr_if,
   output logic              busy_o,
   output logic              done_o,
   output logic [7:0]        frame_cnt_o,
   output logic              overrun_o
);
   localparam int DATA_DEPTH = H_ACTIVE * V_LINES;
   localparam int IDX_W      = $clog2(DATA_DEPTH + 1);
   localparam int X_W        = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W        = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam int SUB_N      = H_ACTIVE / 8;
   localparam int SUB_W      = (SUB_N > 1) ? $clog2(SUB_N) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         mode_q, mode_d;
   logic [15:0]        fg_q, fg_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [SUB_W-1:0]   sub_q, sub_d;
   logic [2:0]         bar_q, bar_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               data_en_q, data_en_d;
   logic [15:0]        dout_q, dout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic               overrun_q, overrun_d;

   logic               x_chk, y_chk;
   logic [5:0]         lum;
   logic [15:0]        idx_lo;
   logic [15:0]        bar_color;
   logic [15:0]        pattern;
   logic               issue;
   logic               start_frame;

   // Narrow counters read as zero above their top bit.
   generate
      if (CHECK_LOG2 < X_W) begin : g_xchk
         assign x_chk = x_q[CHECK_LOG2];
      end else begin : g_xchk0
         assign x_chk = 1'b0;
      end
      if (CHECK_LOG2 < Y_W) begin : g_ychk
         assign y_chk = y_q[CHECK_LOG2];
      end else begin : g_ychk0
         assign y_chk = 1'b0;
      end
      if (X_W >= 6) begin : g_lum
         assign lum = x_q[5:0];
      end else begin : g_lum_ext
         assign lum = 6'(x_q);
      end
      if (IDX_W >= 16) begin : g_idx
         assign idx_lo = idx_q[15:0];
      end else begin : g_idx_ext
         assign idx_lo = 16'(idx_q);
      end
   endgenerate

   always_comb begin
      bar_color = 16'h0000;
      case (bar_q)
         3'd0:    bar_color = 16'hFFFF;
         3'd1:    bar_color = 16'hFFE0;
         3'd2:    bar_color = 16'h07FF;
         3'd3:    bar_color = 16'h07E0;
         3'd4:    bar_color = 16'hF81F;
         3'd5:    bar_color = 16'hF800;
         3'd6:    bar_color = 16'h001F;
         default: bar_color = 16'h0000;
      endcase
   end

   always_comb begin
      pattern = fg_q;
      case (mode_q)
         3'd1:    pattern = bar_color;
         3'd2:    pattern = {lum[5:1], lum, lum[5:1]};
         3'd3:    pattern = (x_chk ^ y_chk) ? fg_q : ~fg_q;
         3'd4:    pattern = idx_lo;
         default: pattern = fg_q;
      endcase
   end

   // The word index runs one past the last word so FILL can see the frame drain.
   assign issue       = (state_q == ST_FILL) && wr_if.wr_en && (idx_q < IDX_W'(DATA_DEPTH));
   assign start_frame = start_i && (state_q != ST_FILL);

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      fg_d        = fg_q;
      x_d         = x_q;
      y_d         = y_q;
      sub_d       = sub_q;
      bar_d       = bar_q;
      idx_d       = idx_q;
      data_en_d   = 1'b0;
      dout_d      = dout_q;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;

      case (state_q)
         ST_IDLE: if (start_i) state_d = ST_FILL;
         ST_FILL: begin
            if (start_i) overrun_d = 1'b1;
            if (idx_q == IDX_W'(DATA_DEPTH)) begin
               state_d     = ST_DONE;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
         ST_DONE: state_d = start_i ? ST_FILL : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (issue) begin
         data_en_d = 1'b1;
         dout_d    = pattern;
         idx_d     = idx_q + 1'b1;
         if (x_q == X_W'(H_ACTIVE - 1)) begin
            x_d   = '0;
            y_d   = y_q + 1'b1;
            sub_d = '0;
            bar_d = '0;
         end else begin
            x_d = x_q + 1'b1;
            if (sub_q == SUB_W'(SUB_N - 1)) begin
               sub_d = '0;
               bar_d = bar_q + 3'd1;
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end
      end

      if (start_frame) begin
         mode_d = mode_i;
         fg_d   = fg_color_i;
         x_d    = '0;
         y_d    = '0;
         sub_d  = '0;
         bar_d  = '0;
         idx_d  = '0;
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= '0;
         fg_q        <= '0;
         x_q         <= '0;
         y_q         <= '0;
         sub_q       <= '0;
         bar_q       <= '0;
         idx_q       <= '0;
         data_en_q   <= 1'b0;
         dout_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         fg_q        <= fg_d;
         x_q         <= x_d;
         y_q         <= y_d;
         sub_q       <= sub_d;
         bar_q       <= bar_d;
         idx_q       <= idx_d;
         data_en_q   <= data_en_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
      end
   end

   assign wr_if.data_en = data_en_q;
   assign wr_if.dout    = dout_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign frame_cnt_o   = frame_cnt_q;
   assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised scoreboard bench: stimulus predicts each word and done pulse with its
// cycle; a negedge monitor pops and compares whatever the generator presents.
module tb_vga_pattern_gen;
   localparam int H  = 16;
   localparam int V  = 8;
   localparam int CL = 2;
   localparam int D  = H * V;
   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  mode_i;
   logic [15:0] fg_color_i;
   logic        busy_o, done_o, overrun_o;
   logic [7:0]  frame_cnt_o;

   vga_pattern_gen_if bus ();

   vga_pattern_gen #(.H_ACTIVE(H), .V_LINES(V), .CHECK_LOG2(CL)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .mode_i      (mode_i),
      .fg_color_i  (fg_color_i),
      .wr_if       (bus.master),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .frame_cnt_o (frame_cnt_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } exp_t;

   exp_t word_q[$];
   exp_t done_q[$];
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   int   frames_exp = 0;
   logic exp_ovr = 1'b0;
   logic wr_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Reference pattern from the pixel's position in the frame.
   function automatic logic [15:0] pat(int idx, int mode, logic [15:0] fg);
      int x, y;
      logic [5:0] l;
      x = idx % H;
      y = idx / H;
      case (mode)
         1: return BARS[x / (H / 8)];
         2: begin
            l = 6'(x % 64);
            return {l[5:1], l, l[5:1]};
         end
         3: return ((((x >> CL) & 1) ^ ((y >> CL) & 1)) != 0) ? fg : ~fg;
         4: return 16'(idx);
         default: return fg;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      while (word_q.size() > 0 && word_q[0].cyc < cyc) begin
         checks++;
         $display("FAIL word_missing: got no data_en, expected word %h at cycle %0d", word_q[0].val, word_q[0].cyc);
         void'(word_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
         checks++;
         $display("FAIL done_missing: got no done_o, expected done at cycle %0d", done_q[0].cyc);
         void'(done_q.pop_front());
      end
      if (bus.data_en === 1'b1) begin
         if (word_q.size() == 0 || word_q[0].cyc != cyc) begin
            checks++;
            $display("FAIL unexpected_data_en: got data_en=1 dout=%h at cycle %0d, expected no word", bus.dout, cyc);
         end else begin
            e = word_q.pop_front();
            check("dout", bus.dout, e.val);
            check("wr_en_before_data_en", 16'(wr_prev), 16'd1);
         end
      end
      if (done_o === 1'b1) begin
         if (done_q.size() == 0 || done_q[0].cyc != cyc) begin
            checks++;
            $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected none", cyc);
         end else begin
            e = done_q.pop_front();
            check("frame_cnt_at_done", 16'(frame_cnt_o), e.val);
            check("busy_at_done", 16'(busy_o), 16'd1);
         end
      end
      wr_prev = bus.wr_en;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle(int pct);
      start_i    = 1'b0;
      mode_i     = 3'($urandom);
      fg_color_i = 16'($urandom);
      bus.wr_en  = ($urandom_range(99) < pct);
   endtask

   // Starts a frame in the current cycle and returns in its DONE cycle.
   task automatic run_frame(int mode, logic [15:0] fg, int pct, bit inject_ovr);
      int   n = 0;
      int   guard = 0;
      bit   injected = 0;
      exp_t e;
      drive_idle(pct);
      start_i    = 1'b1;
      mode_i     = 3'(mode);
      fg_color_i = fg;
      tick();
      while (n < D && guard < 20 * D) begin
         drive_idle(pct);
         if (inject_ovr && !injected && n >= D / 2) begin
            start_i  = 1'b1;
            injected = 1;
            exp_ovr  = 1'b1;
         end
         if (bus.wr_en) begin
            e.cyc = cyc + 1;
            e.val = pat(n, mode, fg);
            word_q.push_back(e);
            n++;
         end
         tick();
         guard++;
      end
      if (n < D) begin
         checks++;
         $display("FAIL frame_budget: got %0d words issued, expected %0d", n, D);
      end
      drive_idle(pct);
      tick();
      frames_exp = (frames_exp + 1) % 256;
      e.cyc = cyc;
      e.val = 16'(frames_exp);
      done_q.push_back(e);
   endtask

   task automatic end_frame();
      drive_idle(50);
      tick();
      drive_idle(50);
      @(negedge clk);
      check("busy_idle", 16'(busy_o), 16'd0);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_data_en"}, 16'(bus.data_en), 16'd0);
      check({tag, "_dout"}, bus.dout, 16'd0);
      check({tag, "_busy"}, 16'(busy_o), 16'd0);
      check({tag, "_done"}, 16'(done_o), 16'd0);
      check({tag, "_frame_cnt"}, 16'(frame_cnt_o), 16'd0);
      check({tag, "_overrun"}, 16'(overrun_o), 16'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle(50);
      tick();
      @(negedge clk);
      check_all_zero("reset");
      rst        = 1'b0;
      frames_exp = 0;
      exp_ovr    = 1'b0;
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: got no completion, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   modes[5] = '{0, 2, 5, 6, 7};
      exp_t e;
      rst = 1'b1;
      start_i = 1'b0;
      mode_i = '0;
      fg_color_i = '0;
      bus.wr_en = 1'b0;
      repeat (2) tick();
      do_reset();

      run_frame(4, 16'h1234, 100, 0);
      end_frame();
      check("frame_cnt_after_first", 16'(frame_cnt_o), 16'd1);

      run_frame(1, 16'($urandom), 70, 0);
      end_frame();
      run_frame(3, 16'hF800, 60, 0);
      end_frame();
      foreach (modes[i]) begin
         run_frame(modes[i], 16'($urandom), $urandom_range(100, 40), 0);
         end_frame();
      end
      run_frame(4, 16'($urandom), 55, 0);
      end_frame();

      run_frame(4, 16'($urandom), 80, 1);
      end_frame();
      check("overrun_mid_fill", 16'(overrun_o), 16'(exp_ovr));

      do_reset();
      for (int i = 0; i < 256; i++)
         run_frame($urandom_range(7), 16'($urandom), $urandom_range(100, 85), 0);
      end_frame();
      check("frame_cnt_wrap", 16'(frame_cnt_o), 16'(frames_exp));
      check("overrun_back_to_back", 16'(overrun_o), 16'd0);

      // Abandon a frame while word 10 is due.
      drive_idle(100);
      start_i = 1'b1;
      mode_i  = 3'd4;
      tick();
      for (int n = 0; n < 10; n++) begin
         drive_idle(100);
         e.cyc = cyc + 1;
         e.val = pat(n, 4, 16'h0);
         word_q.push_back(e);
         tick();
      end
      drive_idle(100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_idle(0);
      @(negedge clk);
      check_all_zero("mid_frame_reset");
      frames_exp = 0;
      exp_ovr    = 1'b0;

      run_frame(4, 16'($urandom), 100, 0);
      end_frame();
      check("frame_cnt_after_rst_frame", 16'(frame_cnt_o), 16'd1);

      repeat (3) tick();
      check("words_outstanding", 16'(word_q.size()), 16'd0);
      check("dones_outstanding", 16'(done_q.size()), 16'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
